// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and fetch control for a 5-stage in-order core.
//
// Detects RAW hazards between the instruction in ID and the one in EX, handles
// ID-stage redirects (taken branch / jump), and holds fetch while instruction
// memory is not ready. Outputs are Mealy: a function of state and current inputs.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   ID_rs, ID_rt            source registers of the ID instruction
//   ID_useRt                ID instruction reads rt
//   ID_branch               ID instruction is a conditional branch resolved in ID
//   EX_rd                   destination register of the EX instruction
//   EX_regWrite, EX_memRead EX instruction writes a register / is a load
//   branch_taken, jump      redirect decided in ID this cycle
//   imem_ready              instruction memory returns a valid word this cycle
//   PCWrite                 PC update enable
//   IFID_write, IFID_flush  IF/ID hold-enable and nop-load
//   IDEX_bubble             zero ID/EX control fields this cycle
//   state                   RUN=00, STALL=01, IMEM_WAIT=10
//   stall_cnt, flush_cnt    saturating performance counters
module hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_useRt,
    input  logic             ID_branch,
    input  logic [4:0]       EX_rd,
    input  logic             EX_regWrite,
    input  logic             EX_memRead,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             imem_ready,
    output logic             PCWrite,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             IDEX_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        StRun       = 2'b00,
        StStall     = 2'b01,
        StImemWait  = 2'b10,
        StUnused    = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       stall_left_q, stall_left_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic match;
    logic haz_load_use;
    logic haz_alu_branch;
    logic haz_load_branch;
    logic hazard;
    logic redirect;
    logic redirect_flush;

    // Hazard detection. r0 is hard-wired zero, so it never creates a dependency.
    always_comb begin
        match = (EX_rd != 5'd0) &&
                ((EX_rd == ID_rs) || (ID_useRt && (EX_rd == ID_rt)));
        haz_load_use    = EX_memRead && match && !ID_branch;
        haz_alu_branch  = ID_branch && EX_regWrite && !EX_memRead && match;
        haz_load_branch = ID_branch && EX_memRead && match;
        hazard          = haz_load_use || haz_alu_branch || haz_load_branch;
        redirect        = branch_taken || jump;
    end

    // Next-state and Mealy outputs.
    always_comb begin
        state_d        = state_q;
        stall_left_d   = stall_left_q;
        PCWrite        = 1'b1;
        IFID_write     = 1'b1;
        IFID_flush     = 1'b0;
        IDEX_bubble    = 1'b0;
        redirect_flush = 1'b0;

        unique case (state_q)
            StRun: begin
                if (hazard) begin
                    // Redirects are ignored while a hazard holds ID.
                    PCWrite     = 1'b0;
                    IFID_write  = 1'b0;
                    IDEX_bubble = 1'b1;
                    if (haz_load_branch) begin
                        // Load data is only available one cycle later still.
                        stall_left_d = 2'd1;
                        state_d      = StStall;
                    end
                end else if (redirect) begin
                    // New target is fetched next cycle regardless of imem_ready.
                    IFID_flush     = 1'b1;
                    redirect_flush = 1'b1;
                end else if (!imem_ready) begin
                    PCWrite    = 1'b0;
                    IFID_flush = 1'b1;
                    state_d    = StImemWait;
                end
            end
            StStall: begin
                PCWrite     = 1'b0;
                IFID_write  = 1'b0;
                IDEX_bubble = 1'b1;
                if (stall_left_q <= 2'd1) begin
                    stall_left_d = 2'd0;
                    state_d      = StRun;
                end else begin
                    stall_left_d = stall_left_q - 2'd1;
                end
            end
            StImemWait: begin
                // ID holds a nop here, so hazard and redirect inputs are stale.
                if (!imem_ready) begin
                    PCWrite    = 1'b0;
                    IFID_flush = 1'b1;
                end else begin
                    state_d = StRun;
                end
            end
            StUnused: begin
                state_d      = StRun;
                stall_left_d = 2'd0;
            end
            default: begin
                state_d      = StRun;
                stall_left_d = 2'd0;
            end
        endcase

        if (reset) begin
            PCWrite        = 1'b0;
            IFID_write     = 1'b0;
            IFID_flush     = 1'b1;
            IDEX_bubble    = 1'b1;
            redirect_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StRun;
            stall_left_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (IDEX_bubble && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redirect_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, EX_rd;
    logic        ID_useRt, ID_branch, EX_regWrite, EX_memRead;
    logic        branch_taken, jump, imem_ready;
    logic        PCWrite, IFID_write, IFID_flush, IDEX_bubble;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .ID_rs        (ID_rs),
        .ID_rt        (ID_rt),
        .ID_useRt     (ID_useRt),
        .ID_branch    (ID_branch),
        .EX_rd        (EX_rd),
        .EX_regWrite  (EX_regWrite),
        .EX_memRead   (EX_memRead),
        .branch_taken (branch_taken),
        .jump         (jump),
        .imem_ready   (imem_ready),
        .PCWrite      (PCWrite),
        .IFID_write   (IFID_write),
        .IFID_flush   (IFID_flush),
        .IDEX_bubble  (IDEX_bubble),
        .state        (state),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs as {PCWrite, IFID_write, IFID_flush, IDEX_bubble}.
    typedef struct {
        logic [3:0]  outs;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: one expected entry per driven cycle, checked mid-cycle.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] act;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {PCWrite, IFID_write, IFID_flush, IDEX_bubble};
            n_tests++;
            if (act !== e.outs || state !== e.st || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                n_fail++;
                $display("FAIL %s: got outs=%b st=%b sc=%h fc=%h, expected outs=%b st=%b sc=%h fc=%h",
                         e.name, act, state, stall_cnt, flush_cnt, e.outs, e.st, e.sc, e.fc);
            end
        end
    end

    // Drive one cycle of inputs shortly after posedge; optionally queue its expectation.
    task automatic step(input bit push, input string name, input logic r,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic brn, input logic [4:0] rd, input logic rw, input logic mr,
                        input logic bt, input logic jmp, input logic rdy,
                        input logic [3:0] outs, input logic [1:0] st,
                        input logic [15:0] sc, input logic [15:0] fc);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = r;
        ID_rs        = rs;
        ID_rt        = rt;
        ID_useRt     = urt;
        ID_branch    = brn;
        EX_rd        = rd;
        EX_regWrite  = rw;
        EX_memRead   = mr;
        branch_taken = bt;
        jump         = jmp;
        imem_ready   = rdy;
        if (push) begin
            e.outs = outs; e.st = st; e.sc = sc; e.fc = fc; e.name = name;
            q.push_back(e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; ID_rs = 0; ID_rt = 0; ID_useRt = 0; ID_branch = 0; EX_rd = 0;
        EX_regWrite = 0; EX_memRead = 0; branch_taken = 0; jump = 0; imem_ready = 1;

        //   push name           rst rs  rt  urt br rd  rw mr bt jp rdy outs     st     sc       fc
        step(1, "reset_state",   1,  0,  0,  0,  0, 0,  0, 0, 0, 0, 1, 4'b0011, 2'b00, 16'd0,  16'd0);
        step(1, "normal",        0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 1, 4'b1100, 2'b00, 16'd0,  16'd0);
        step(1, "load_use",      0,  5,  0,  0,  0, 5,  1, 1, 0, 0, 1, 4'b0001, 2'b00, 16'd0,  16'd0);
        step(1, "after_lu",      0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 1, 4'b1100, 2'b00, 16'd1,  16'd0);
        step(1, "ld_br_1",       0,  0,  3,  1,  1, 3,  1, 1, 1, 0, 1, 4'b0001, 2'b00, 16'd1,  16'd0);
        step(1, "ld_br_2",       0,  0,  3,  1,  1, 3,  1, 1, 1, 0, 1, 4'b0001, 2'b01, 16'd2,  16'd0);
        step(1, "after_ldbr",    0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 1, 4'b1100, 2'b00, 16'd3,  16'd0);
        step(1, "r0_no_haz",     0,  0,  0,  0,  0, 0,  1, 1, 0, 0, 1, 4'b1100, 2'b00, 16'd3,  16'd0);
        step(1, "r0_redirect",   0,  0,  0,  0,  0, 0,  1, 1, 1, 0, 1, 4'b1110, 2'b00, 16'd3,  16'd0);
        step(1, "after_redir",   0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 1, 4'b1100, 2'b00, 16'd3,  16'd1);
        step(1, "jump_no_rdy",   0,  0,  0,  0,  0, 0,  0, 0, 0, 1, 0, 4'b1110, 2'b00, 16'd3,  16'd1);
        step(1, "after_jump",    0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 1, 4'b1100, 2'b00, 16'd3,  16'd2);
        step(1, "alu_br_taken",  0,  7,  0,  0,  1, 7,  1, 0, 1, 0, 1, 4'b0001, 2'b00, 16'd3,  16'd2);
        step(1, "after_alubr",   0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 1, 4'b1100, 2'b00, 16'd4,  16'd2);
        step(1, "rt_unused",     0,  1,  9,  0,  0, 9,  1, 1, 0, 0, 1, 4'b1100, 2'b00, 16'd4,  16'd2);
        step(1, "rt_used",       0,  1,  9,  1,  0, 9,  1, 1, 0, 0, 1, 4'b0001, 2'b00, 16'd4,  16'd2);
        step(1, "imem_miss_1",   0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 0, 4'b0110, 2'b00, 16'd5,  16'd2);
        step(1, "imem_miss_2",   0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 0, 4'b0110, 2'b10, 16'd5,  16'd2);
        step(1, "imem_ign_haz",  0,  5,  0,  0,  0, 5,  1, 1, 1, 0, 0, 4'b0110, 2'b10, 16'd5,  16'd2);
        step(1, "imem_ready",    0,  5,  0,  0,  0, 5,  1, 1, 0, 0, 1, 4'b1100, 2'b10, 16'd5,  16'd2);
        step(1, "back_to_run",   0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 1, 4'b1100, 2'b00, 16'd5,  16'd2);
        step(1, "haz_over_miss", 0,  5,  0,  0,  0, 5,  1, 1, 0, 0, 0, 4'b0001, 2'b00, 16'd5,  16'd2);
        step(1, "after_hom",     0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 1, 4'b1100, 2'b00, 16'd6,  16'd2);
        step(1, "ld_br_again",   0,  0,  3,  1,  1, 3,  1, 1, 1, 0, 1, 4'b0001, 2'b00, 16'd6,  16'd2);
        step(1, "rst_mid_stall", 1,  0,  3,  1,  1, 3,  1, 1, 1, 0, 1, 4'b0011, 2'b00, 16'd0,  16'd0);
        step(1, "post_rst_1",    0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 1, 4'b1100, 2'b00, 16'd0,  16'd0);
        step(1, "miss_pre_rst",  0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 0, 4'b0110, 2'b00, 16'd0,  16'd0);
        step(1, "rst_mid_wait",  1,  0,  0,  0,  0, 0,  0, 0, 0, 0, 0, 4'b0011, 2'b00, 16'd0,  16'd0);
        step(1, "post_rst_2",    0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 1, 4'b1100, 2'b00, 16'd0,  16'd0);

        // Preload stall_cnt with forced load-use bubbles.
        for (int i = 0; i < 65534; i++) begin
            step(0, "preload",   0,  5,  0,  0,  0, 5,  1, 1, 0, 0, 1, 4'b0001, 2'b00, 16'd0,  16'd0);
        end
        step(1, "sat_fffe",      0,  5,  0,  0,  0, 5,  1, 1, 0, 0, 1, 4'b0001, 2'b00, 16'hFFFE, 16'd0);
        step(1, "sat_ffff",      0,  5,  0,  0,  0, 5,  1, 1, 0, 0, 1, 4'b0001, 2'b00, 16'hFFFF, 16'd0);
        step(1, "sat_hold",      0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 1, 4'b1100, 2'b00, 16'hFFFF, 16'd0);
        step(1, "sat_final",     0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 1, 4'b1100, 2'b00, 16'hFFFF, 16'd0);

        @(posedge clk);
        @(posedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
